// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC rotation-mode sequencer.
// A single shift-add datapath is reused for ITER micro-rotations, one per
// clock. The block owns the iteration counter, the arctangent lookup, the
// variable shift amount and the valid/ready handshakes on both sides.
module cordic_iter_ctrl #(
    parameter int ITER  = 16,
    parameter int CNT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [31:0]      x_in,
    input  logic signed [31:0]      y_in,
    input  logic signed [31:0]      z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [31:0]      x_out,
    output logic signed [31:0]      y_out,
    output logic signed [31:0]      z_out,
    output logic                    busy,
    output logic [CNT_W-1:0]        iter_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITER - 1);

    state_t                 state_q, state_nx;
    logic [CNT_W-1:0]       iter_q, iter_nx;
    logic signed [31:0]     x_q, y_q, z_q;
    logic signed [31:0]     x_nx, y_nx, z_nx;
    logic signed [31:0]     x_sh, y_sh, atan_i;

    // trunc(atan(2^-i) * 2^30). For i >= 10 the cubic term is below one LSB
    // but still strictly positive, so the truncated value is 2^(30-i) - 1.
    function automatic logic signed [31:0] atan_lut(input logic [CNT_W-1:0] i);
        logic [31:0] idx;
        idx = 32'(i);
        case (idx)
            32'd0:   atan_lut = 32'sh3243F6A8;
            32'd1:   atan_lut = 32'sh1DAC6705;
            32'd2:   atan_lut = 32'sh0FADBAFC;
            32'd3:   atan_lut = 32'sh07F56EA6;
            32'd4:   atan_lut = 32'sh03FEAB76;
            32'd5:   atan_lut = 32'sh01FFD55B;
            32'd6:   atan_lut = 32'sh00FFFAAA;
            32'd7:   atan_lut = 32'sh007FFF55;
            32'd8:   atan_lut = 32'sh003FFFEA;
            32'd9:   atan_lut = 32'sh001FFFFD;
            32'd10:  atan_lut = 32'sh000FFFFF;
            32'd11:  atan_lut = 32'sh0007FFFF;
            32'd12:  atan_lut = 32'sh0003FFFF;
            32'd13:  atan_lut = 32'sh0001FFFF;
            32'd14:  atan_lut = 32'sh0000FFFF;
            32'd15:  atan_lut = 32'sh00007FFF;
            32'd16:  atan_lut = 32'sh00003FFF;
            32'd17:  atan_lut = 32'sh00001FFF;
            32'd18:  atan_lut = 32'sh00000FFF;
            32'd19:  atan_lut = 32'sh000007FF;
            32'd20:  atan_lut = 32'sh000003FF;
            32'd21:  atan_lut = 32'sh000001FF;
            32'd22:  atan_lut = 32'sh000000FF;
            32'd23:  atan_lut = 32'sh0000007F;
            32'd24:  atan_lut = 32'sh0000003F;
            32'd25:  atan_lut = 32'sh0000001F;
            32'd26:  atan_lut = 32'sh0000000F;
            32'd27:  atan_lut = 32'sh00000007;
            32'd28:  atan_lut = 32'sh00000003;
            32'd29:  atan_lut = 32'sh00000001;
            default: atan_lut = 32'sh00000000;
        endcase
    endfunction

    // Arithmetic right shift by the current iteration index.
    function automatic logic signed [31:0] asr(input logic signed [31:0] v,
                                               input logic [CNT_W-1:0] s);
        asr = v >>> s;
    endfunction

    assign x_sh   = asr(x_q, iter_q);
    assign y_sh   = asr(y_q, iter_q);
    assign atan_i = atan_lut(iter_q);

    // Next-state, counter and micro-rotation datapath.
    always_comb begin
        state_nx = state_q;
        iter_nx  = iter_q;
        x_nx     = x_q;
        y_nx     = y_q;
        z_nx     = z_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_nx = S_RUN;
                    iter_nx  = '0;
                    x_nx     = x_in;
                    y_nx     = y_in;
                    z_nx     = z_in;
                end
            end
            S_RUN: begin
                // Zero residual angle rotates in the negative direction.
                if (z_q > 32'sd0) begin
                    x_nx = x_q - y_sh;
                    y_nx = y_q + x_sh;
                    z_nx = z_q - atan_i;
                end else begin
                    x_nx = x_q + y_sh;
                    y_nx = y_q - x_sh;
                    z_nx = z_q + atan_i;
                end
                iter_nx = iter_q + CNT_W'(1);
                if (iter_q == LAST_IDX) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                // Leaving DONE always passes through IDLE for one cycle.
                if (out_ready) begin
                    state_nx = S_IDLE;
                    iter_nx  = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                iter_nx  = '0;
            end
        endcase
    end

    // State, counter and working registers; reset discards any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_nx;
            iter_q  <= iter_nx;
            x_q     <= x_nx;
            y_q     <= y_nx;
            z_q     <= z_nx;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign z_out     = z_q;
    assign iter_idx  = iter_q;

endmodule
